// File: rtl/dtree_pkg.sv
// Shared constants, loader state encoding and feature-slot map
// for the decision-tree front end.
package dtree_pkg;

  localparam int FEAT_W       = 8;
  localparam int CLASS_W      = 2;
  localparam int NUM_FEATURES = 18;
  localparam int IDX_W        = $clog2(NUM_FEATURES);
  localparam int VEC_W        = NUM_FEATURES * FEAT_W;
  localparam int FRM_W        = 16;

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    EVAL,
    OUT
  } ldr_state_t;

  // Tree inputs X4/X5 are unused, so slots 4.. skip ahead by two
  localparam int X_MAP [NUM_FEATURES] = '{
    0, 1, 2, 3, 6, 7, 8, 9, 10,
    11, 12, 13, 14, 15, 16, 17, 18, 19
  };

  function automatic int slot_to_x(input int slot);
    return X_MAP[slot];
  endfunction

endpackage

// File: rtl/dtree_feature_loader_if.sv
// Byte-stream in / class-result out handshake bundle
// between host and feature loader.
interface dtree_feature_loader_if;
  import dtree_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [FEAT_W-1:0]  s_data;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [CLASS_W-1:0] m_class;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_class
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_class
  );

endinterface

// File: rtl/dtree_feature_loader.sv
// Deserialises feature bytes into the tree vector, waits for the
// tree to settle, then returns the captured class.
module dtree_feature_loader
  import dtree_pkg::*;
#(
  parameter int TREE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dtree_feature_loader_if.slave bus,
  output logic [VEC_W-1:0]     feat_vec,
  input  logic [CLASS_W-1:0]   cls_in,
  output logic                 err_len,
  output logic [FRM_W-1:0]     frames
);

  localparam int CNT_W =
    (TREE_LAT > 0) ? $clog2(TREE_LAT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_FEATURES - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TREE_LAT);

  ldr_state_t         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   feat_q, feat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CLASS_W-1:0] cls_q, cls_d;
  logic               mval_q, mval_d;
  logic               err_q, err_d;
  logic [FRM_W-1:0]   frames_q, frames_d;
  logic               rdy_q;
  logic               accept;

  assign accept = bus.s_valid & bus.s_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      feat_q   <= '0;
      cnt_q    <= '0;
      cls_q    <= '0;
      mval_q   <= 1'b0;
      err_q    <= 1'b0;
      frames_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      feat_q   <= feat_d;
      cnt_q    <= cnt_d;
      cls_q    <= cls_d;
      mval_q   <= mval_d;
      err_q    <= err_d;
      frames_q <= frames_d;
      rdy_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    feat_d   = feat_q;
    cnt_d    = cnt_q;
    cls_d    = cls_q;
    mval_d   = mval_q;
    err_d    = 1'b0;
    frames_d = frames_q;
    unique case (1'b1)
      state_q == LOAD: begin
        if (accept) begin
          feat_d[int'(idx_q)*FEAT_W +: FEAT_W] = bus.s_data;
          idx_d = idx_q + IDX_W'(1);
          if (bus.s_last) begin
            idx_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = EVAL;
              cnt_d   = CNT_INIT;
            end else begin
              err_d = 1'b1;
            end
          end else if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      state_q == DRAIN: begin
        if (accept && bus.s_last) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      state_q == EVAL: begin
        // Zero latency captures in the entry cycle itself
        if (cnt_q == '0) begin
          cls_d   = cls_in;
          mval_d  = 1'b1;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      state_q == OUT: begin
        if (bus.m_ready) begin
          mval_d  = 1'b0;
          state_d = LOAD;
          if (frames_q != '1) frames_d = frames_q + FRM_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.s_ready = rdy_q &
      ((state_q == LOAD) | (state_q == DRAIN));
    bus.m_valid = mval_q;
    bus.m_class = cls_q;
    feat_vec    = feat_q;
    err_len     = err_q;
    frames      = frames_q;
  end

endmodule
